// File: rtl/crc_sequencer_if.sv
// Byte-stream input and result output handshake bundle for crc_sequencer.
//   in_valid/in_data/in_last/in_ready : message byte stream (producer -> sequencer)
//   out_valid/out_crc/out_ready       : finished CRC result (sequencer -> consumer)
// master = stream producer / result consumer, slave = the CRC sequencer.
interface crc_sequencer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_crc;
  logic        out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_crc
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_crc
  );
endinterface

// File: rtl/crc_sequencer.sv
// Bit-serial CRC engine with runtime-configurable width (8..64 bits in byte
// steps), polynomial, init, final XOR and input/output reflection.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_load            : latch all cfg_* inputs (honoured in READY only)
//   cfg_width           : CRC width in bytes minus one
//   cfg_poly/init/xorout: polynomial (implicit top bit omitted), seed, final XOR
//   cfg_refin/refout    : per-byte input reflection, whole-result reflection
//   clear               : synchronous abort of the current message
//   busy                : high while shifting or finalising
//   bus (slave)         : byte stream in, result out
module crc_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [2:0]           cfg_width,
  input  logic [63:0]          cfg_poly,
  input  logic [63:0]          cfg_init,
  input  logic [63:0]          cfg_xorout,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
  input  logic                 clear,
  output logic                 busy,
  crc_sequencer_if.slave       bus
);

  localparam int unsigned CRC_W  = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    READY = 2'd0,
    SHIFT = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // All-ones in the low 8*(w+1) bits.
  function automatic logic [CRC_W-1:0] width_mask(input logic [2:0] w);
    return {CRC_W{1'b1}} >> (6'd56 - {w, 3'b000});
  endfunction

  // Bit-reverse the low 8*(w+1) bits: full 64-bit reverse, then drop the
  // (zero) bits that came from above the active width.
  function automatic logic [CRC_W-1:0] reflect_w(input logic [CRC_W-1:0] v,
                                                 input logic [2:0]       w);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r >> (6'd56 - {w, 3'b000});
  endfunction

  state_t             state;

  // Latched configuration (poly/init/xorout stored pre-masked to the width)
  logic [2:0]         width_q;
  logic [CRC_W-1:0]   poly_q;
  logic [CRC_W-1:0]   init_q;
  logic [CRC_W-1:0]   xorout_q;
  logic               refin_q;
  logic               refout_q;

  // Datapath state
  logic [CRC_W-1:0]   crc_q;
  logic [BYTE_W-1:0]  data_q;
  logic               last_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               out_valid_q;
  logic [CRC_W-1:0]   out_crc_q;

  // Combinational step terms
  logic [CRC_W-1:0]   mask;
  logic               bit_in;
  logic               fb;
  logic [CRC_W-1:0]   crc_step;
  logic [CRC_W-1:0]   crc_refl;
  logic [CRC_W-1:0]   crc_final;
  logic [CRC_W-1:0]   load_mask;

  assign mask      = width_mask(width_q);
  assign load_mask = width_mask(cfg_width);

  // LSB-first when reflecting input; ~bit_cnt == 7-bit_cnt gives MSB-first.
  assign bit_in    = refin_q ? data_q[bit_cnt] : data_q[~bit_cnt];

  // Feedback taken from the top bit of the active width.
  assign fb        = crc_q[{width_q, 3'b111}] ^ bit_in;
  assign crc_step  = ((crc_q << 1) & mask) ^ (fb ? poly_q : {CRC_W{1'b0}});

  assign crc_refl  = reflect_w(crc_q, width_q);
  assign crc_final = ((refout_q ? crc_refl : crc_q) ^ xorout_q) & mask;

  // Ready is withheld while a config load or abort is being applied.
  assign bus.in_ready  = (state == READY) && !cfg_load && !clear;
  assign bus.out_valid = out_valid_q;
  assign bus.out_crc   = out_crc_q;
  assign busy          = (state == SHIFT) || (state == FINAL);

  // Sequencer: state, configuration and CRC datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= READY;
      width_q     <= 3'd0;
      poly_q      <= {CRC_W{1'b0}};
      init_q      <= {CRC_W{1'b0}};
      xorout_q    <= {CRC_W{1'b0}};
      refin_q     <= 1'b0;
      refout_q    <= 1'b0;
      crc_q       <= {CRC_W{1'b0}};
      data_q      <= {BYTE_W{1'b0}};
      last_q      <= 1'b0;
      bit_cnt     <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_crc_q   <= {CRC_W{1'b0}};
    end else if (clear) begin
      // Abort: configuration and the last published result are kept.
      state       <= READY;
      crc_q       <= init_q;
      out_valid_q <= 1'b0;
      bit_cnt     <= {CNT_W{1'b0}};
    end else begin
      case (state)
        READY: begin
          if (cfg_load) begin
            width_q  <= cfg_width;
            poly_q   <= cfg_poly & load_mask;
            init_q   <= cfg_init & load_mask;
            xorout_q <= cfg_xorout & load_mask;
            refin_q  <= cfg_refin;
            refout_q <= cfg_refout;
            crc_q    <= cfg_init & load_mask;
          end else if (bus.in_valid) begin
            data_q  <= bus.in_data;
            last_q  <= bus.in_last;
            bit_cnt <= {CNT_W{1'b0}};
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          crc_q   <= crc_step;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(7)) begin
            state <= last_q ? FINAL : READY;
          end
        end

        FINAL: begin
          out_crc_q <= crc_final;
          state     <= DONE;
        end

        DONE: begin
          // Result is captured leaving FINAL; valid is raised on the first
          // DONE edge and held until the consumer takes it.
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            crc_q       <= init_q;
            state       <= READY;
          end else begin
            out_valid_q <= 1'b1;
          end
        end

        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_sequencer.sv
// Self-checking bench for crc_sequencer: catalogue CRC vectors, handshake,
// abort and reset cases, plus randomised configurations against a bytewise
// reference model. Results are checked through a scoreboard queue.
module tb_crc_sequencer;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst;
  logic        cfg_load;
  logic [2:0]  cfg_width;
  logic [63:0] cfg_poly;
  logic [63:0] cfg_init;
  logic [63:0] cfg_xorout;
  logic        cfg_refin;
  logic        cfg_refout;
  logic        clear;
  logic        busy;

  crc_sequencer_if bus_if();

  crc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_width  (cfg_width),
    .cfg_poly   (cfg_poly),
    .cfg_init   (cfg_init),
    .cfg_xorout (cfg_xorout),
    .cfg_refin  (cfg_refin),
    .cfg_refout (cfg_refout),
    .clear      (clear),
    .busy       (busy),
    .bus        (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          acc_cyc;
  logic [63:0] sb[$];

  // Model configuration mirrors what was last loaded.
  logic [2:0]  cur_w;
  logic [63:0] cur_poly, cur_init, cur_xorout;
  logic        cur_refin, cur_refout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytewise reference CRC.
  function automatic logic [63:0] crc_model(input logic [2:0] wsel, input logic [63:0] poly,
                                            input logic [63:0] init, input logic [63:0] xorout,
                                            input logic refin, input logic refout,
                                            input byte_q_t msg);
    int          w;
    logic [63:0] m, crc, r;
    logic [7:0]  b;
    logic        top;
    w   = 8 * (int'(wsel) + 1);
    m   = {64{1'b1}} >> (64 - w);
    crc = init & m;
    foreach (msg[k]) begin
      b = msg[k];
      if (refin) for (int i = 0; i < 8; i++) b[i] = msg[k][7-i];
      crc = crc ^ (64'(b) << (w - 8));
      for (int i = 0; i < 8; i++) begin
        top = crc[w-1];
        crc = (crc << 1) & m;
        if (top) crc = crc ^ (poly & m);
      end
    end
    r = crc;
    if (refout) begin
      r = '0;
      for (int i = 0; i < w; i++) r[i] = crc[w-1-i];
    end
    return (r ^ xorout) & m;
  endfunction

  // Scoreboard: compare each consumed result with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus_if.out_valid && bus_if.out_ready) begin
      if (sb.size() == 0) chk("sb_unexpected_result", 64'd1, 64'd0);
      else                chk("crc_result", bus_if.out_crc, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus_if.in_ready && n < 200) begin
      step();
      n++;
    end
    if (!bus_if.in_ready) chk("ready_timeout", 64'(bus_if.in_ready), 64'd1);
  endtask

  task automatic configure(input logic [2:0] w, input logic [63:0] poly, input logic [63:0] init,
                           input logic [63:0] xo, input logic ri, input logic ro);
    wait_ready();
    cfg_width = w; cfg_poly = poly; cfg_init = init; cfg_xorout = xo;
    cfg_refin = ri; cfg_refout = ro;
    cur_w = w; cur_poly = poly; cur_init = init; cur_xorout = xo;
    cur_refin = ri; cur_refout = ro;
    cfg_load = 1'b1;
    #1;
    chk("in_ready_during_cfg", 64'(bus_if.in_ready), 64'd0);
    step();
    cfg_load = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    wait_ready();
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    bus_if.in_last  = l;
    step();
    acc_cyc = cyc;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'h00;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus_if.out_valid && n < 40);
    if (!bus_if.out_valid) chk("result_timeout", 64'(bus_if.out_valid), 64'd1);
  endtask

  task automatic run_msg(input byte_q_t m, input logic [63:0] exp);
    int prev, n;
    prev = 0;
    foreach (m[i]) begin
      if (i == m.size() - 1) sb.push_back(exp);
      send_byte(m[i], i == m.size() - 1);
      if (i > 0) chk("byte_spacing", 64'(acc_cyc - prev), 64'd9);
      prev = acc_cyc;
    end
    wait_result(n);
    chk("latency", 64'(n), 64'd10);
  endtask

  byte_q_t     msg9, rmsg;
  logic [2:0]  r_w;
  logic [63:0] r_poly, r_init, r_xo;
  logic        r_ri, r_ro;
  int          lat;

  initial begin
    for (int i = 1; i <= 9; i++) msg9.push_back(8'h30 + 8'(i));

    rst = 1'b1; cfg_load = 1'b0; clear = 1'b0;
    cfg_width = '0; cfg_poly = '0; cfg_init = '0; cfg_xorout = '0;
    cfg_refin = 1'b0; cfg_refout = 1'b0;
    bus_if.in_valid = 1'b0; bus_if.in_data = '0; bus_if.in_last = 1'b0;
    bus_if.out_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst_out_crc", bus_if.out_crc, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
    clear = 1'b1;
    #1;
    chk("rst_in_ready_clear", 64'(bus_if.in_ready), 64'd0);
    clear = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // cfg_load together with in_valid: config applied, byte not taken
    wait_ready();
    cfg_width = 3'd0; cfg_poly = 64'h07; cfg_init = '0; cfg_xorout = '0;
    cfg_refin = 1'b0; cfg_refout = 1'b0;
    cur_w = 3'd0; cur_poly = 64'h07; cur_init = '0; cur_xorout = '0;
    cur_refin = 1'b0; cur_refout = 1'b0;
    cfg_load = 1'b1;
    bus_if.in_valid = 1'b1; bus_if.in_data = 8'h31; bus_if.in_last = 1'b1;
    step();
    cfg_load = 1'b0; bus_if.in_valid = 1'b0; bus_if.in_last = 1'b0;
    chk("cfg_wins_no_accept", 64'(busy), 64'd0);

    // CRC-8
    run_msg(msg9, 64'h00000000000000F4);

    // CRC-16/CCITT-FALSE with an ignored cfg_load mid-SHIFT
    configure(3'd1, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0);
    foreach (msg9[i]) begin
      if (i == 8) sb.push_back(64'h29B1);
      send_byte(msg9[i], i == 8);
      if (i == 4) begin
        step(); step();
        cfg_width = 3'd7; cfg_poly = 64'hDEAD_BEEF_0123_4567; cfg_init = 64'h5555;
        cfg_xorout = 64'hFFFF; cfg_refin = 1'b1; cfg_refout = 1'b1;
        cfg_load = 1'b1;
        #1;
        chk("in_ready_cfg_shift", 64'(bus_if.in_ready), 64'd0);
        chk("busy_in_shift", 64'(busy), 64'd1);
        step();
        cfg_load = 1'b0;
      end
    end
    wait_result(lat);
    chk("latency_crc16", 64'(lat), 64'd10);

    // CRC-32
    configure(3'd3, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1);
    run_msg(msg9, 64'hCBF43926);

    // CRC-64/XZ
    configure(3'd7, 64'h42F0E1EBA9EA3693, {64{1'b1}}, {64{1'b1}}, 1'b1, 1'b1);
    run_msg(msg9, 64'h995DC9BBDF1939FA);

    // CRC-32 with consumer stalled 5 cycles in DONE
    configure(3'd3, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1);
    bus_if.out_ready = 1'b0;
    run_msg(msg9, 64'hCBF43926);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(bus_if.out_valid), 64'd1);
      chk("hold_crc", bus_if.out_crc, 64'hCBF43926);
      chk("hold_in_ready", 64'(bus_if.in_ready), 64'd0);
    end
    bus_if.out_ready = 1'b1;
    step();
    chk("post_hs_valid", 64'(bus_if.out_valid), 64'd0);
    chk("post_hs_crc_kept", bus_if.out_crc, 64'hCBF43926);
    chk("post_hs_in_ready", 64'(bus_if.in_ready), 64'd1);

    // clear during the 4th SHIFT cycle, then a clean CRC-32 run
    send_byte(8'h31, 1'b0);
    step(); step(); step();
    chk("busy_before_clear", 64'(busy), 64'd1);
    clear = 1'b1;
    #1;
    chk("in_ready_clear", 64'(bus_if.in_ready), 64'd0);
    step();
    clear = 1'b0;
    #1;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_in_ready", 64'(bus_if.in_ready), 64'd1);
    run_msg(msg9, 64'hCBF43926);

    // Asynchronous reset mid-SHIFT of a CRC-32 message
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("arst_out_crc", bus_if.out_crc, 64'd0);
    chk("arst_in_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    rst = 1'b0;
    // Default (reset) configuration: W=8, poly=0 -> result 0
    cur_w = '0; cur_poly = '0; cur_init = '0; cur_xorout = '0;
    cur_refin = 1'b0; cur_refout = 1'b0;
    rmsg = {8'hA5, 8'h3C};
    run_msg(rmsg, crc_model(cur_w, cur_poly, cur_init, cur_xorout, cur_refin, cur_refout, rmsg));
    configure(3'd3, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1);
    run_msg(msg9, 64'hCBF43926);

    // Randomised configurations against the reference model
    for (int t = 0; t < 6; t++) begin
      r_w    = 3'($urandom_range(0, 7));
      r_poly = {$urandom, $urandom};
      r_init = {$urandom, $urandom};
      r_xo   = {$urandom, $urandom};
      r_ri   = 1'($urandom_range(0, 1));
      r_ro   = 1'($urandom_range(0, 1));
      configure(r_w, r_poly, r_init, r_xo, r_ri, r_ro);
      rmsg.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) rmsg.push_back(8'($urandom));
      run_msg(rmsg, crc_model(cur_w, cur_poly, cur_init, cur_xorout, cur_refin, cur_refout, rmsg));
    end

    step(); step(); step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
